// File: rtl/e203_exu_dsp_bigadder_arb.sv
// Round-robin arbiter sharing the DSP big adder among NREQ sub-units, with a one-entry response buffer.
// Optional requester lock for multi-beat operations: define E203_DSP_BIGADDER_ARB_LOCK_EN.
`ifndef E203_DSP_BIGADDER_WIDTH
`define E203_DSP_BIGADDER_WIDTH 40
`endif

module e203_exu_dsp_bigadder_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 2,
    parameter int AW   = `E203_DSP_BIGADDER_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_op1,
    input  logic [NREQ*AW-1:0]   req_op2,
`ifdef E203_DSP_BIGADDER_ARB_LOCK_EN
    input  logic [NREQ-1:0]      req_lock,
`endif
    output logic [AW-1:0]        adder_op1_o,
    output logic [AW-1:0]        adder_op2_o,
    input  logic [AW-1:0]        adder_res_i,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [AW-1:0]        rsp_res,
    output logic [IDW-1:0]       rsp_id
);

    logic            buf_vld;
    logic [AW-1:0]   buf_res;
    logic [IDW-1:0]  buf_id;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_nxt;
    logic [IDW-1:0]  gnt_id;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic            can_acc;
    logic            hs;
    logic            ptr_adv;

`ifdef E203_DSP_BIGADDER_ARB_LOCK_EN
    logic            lock_vld;
    logic [IDW-1:0]  lock_id;
    logic            gnt_lock;

    assign gnt_lock = |(gnt & req_lock);
`endif

    assign can_acc = ~buf_vld | rsp_ready;

    // While a lock is held only the lock owner stays eligible.
    always_comb begin
        elig = req_valid;
`ifdef E203_DSP_BIGADDER_ARB_LOCK_EN
        for (int unsigned i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] & (~lock_vld | (lock_id == IDW'(i)));
        end
`endif
    end

    // Search order ptr, ptr+1, ... modulo NREQ; first eligible requester wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        hs     = 1'b0;
        if (can_acc) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (!hs && elig[i] && (((32'(ptr) + k) % NREQ) == i)) begin
                        gnt[i] = 1'b1;
                        gnt_id = IDW'(i);
                        hs     = 1'b1;
                    end
                end
            end
        end
    end

    assign req_ready = gnt;
    assign ptr_nxt   = IDW'((32'(gnt_id) + 32'd1) % NREQ);

    always_comb begin
        ptr_adv = 1'b1;
`ifdef E203_DSP_BIGADDER_ARB_LOCK_EN
        ptr_adv = ~(lock_vld & gnt_lock);
`endif
    end

    always_comb begin
        adder_op1_o = '0;
        adder_op2_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                adder_op1_o = adder_op1_o | req_op1[i*AW +: AW];
                adder_op2_o = adder_op2_o | req_op2[i*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld <= 1'b0;
            buf_res <= '0;
            buf_id  <= '0;
            ptr     <= '0;
        end else if (hs) begin
            buf_vld <= 1'b1;
            buf_res <= adder_res_i;
            buf_id  <= gnt_id;
            if (ptr_adv) begin
                ptr <= ptr_nxt;
            end
        end else if (rsp_ready) begin
            buf_vld <= 1'b0;
        end
    end

`ifdef E203_DSP_BIGADDER_ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_vld <= 1'b0;
            lock_id  <= '0;
        end else if (hs) begin
            lock_vld <= gnt_lock;
            if (gnt_lock) begin
                lock_id <= gnt_id;
            end
        end
    end
`endif

    assign rsp_valid = buf_vld;
    assign rsp_res   = buf_res;
    assign rsp_id    = buf_id;

endmodule

// File: tb/tb_e203_exu_dsp_bigadder_arb.sv
// Directed self-checking bench for e203_exu_dsp_bigadder_arb (NREQ=2, AW=40).
module tb_e203_exu_dsp_bigadder_arb;

    localparam int NREQ = 2;
    localparam int IDW  = 2;
    localparam int AW   = 40;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*AW-1:0]  req_op1;
    logic [NREQ*AW-1:0]  req_op2;
`ifdef E203_DSP_BIGADDER_ARB_LOCK_EN
    logic [NREQ-1:0]     req_lock;
`endif
    logic [AW-1:0]       adder_op1_o;
    logic [AW-1:0]       adder_op2_o;
    logic [AW-1:0]       adder_res_i;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [AW-1:0]       rsp_res;
    logic [IDW-1:0]      rsp_id;

    int n_cmp = 0;
    int n_err = 0;

    e203_exu_dsp_bigadder_arb #(.NREQ(NREQ), .IDW(IDW), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op1     (req_op1),
        .req_op2     (req_op2),
`ifdef E203_DSP_BIGADDER_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .adder_op1_o (adder_op1_o),
        .adder_op2_o (adder_op2_o),
        .adder_res_i (adder_res_i),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_res     (rsp_res),
        .rsp_id      (rsp_id)
    );

    // Behavioural big adder, wraps modulo 2^AW.
    assign adder_res_i = adder_op1_o + adder_op2_o;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] v, input logic [39:0] a0, input logic [39:0] b0,
                           input logic [39:0] a1, input logic [39:0] b1);
        req_valid = v;
        req_op1   = {a1, a0};
        req_op2   = {b1, b0};
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  exp_g;
        logic [1:0]  exp_id;
        logic [63:0] exp_res;

        rst_n     = 1'b0;
        rsp_ready = 1'b0;
`ifdef E203_DSP_BIGADDER_ARB_LOCK_EN
        req_lock  = '0;
`endif
        set_req(2'b00, 40'h0, 40'h0, 40'h0, 40'h0);
        #3;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_res", 64'(rsp_res), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_adder_op1", 64'(adder_op1_o), 64'd0);
        step();
        rst_n = 1'b1;

        // Single request from requester 0
        set_req(2'b01, 40'h00_0000_00FF, 40'h1, 40'h0, 40'h0);
        #3;
        check("single_ready", 64'(req_ready), 64'h1);
        check("single_op1", 64'(adder_op1_o), 64'hFF);
        check("single_op2", 64'(adder_op2_o), 64'h1);
        step();
        set_req(2'b00, 40'h0, 40'h0, 40'h0, 40'h0);
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_res", 64'(rsp_res), 64'h100);
        check("single_id", 64'(rsp_id), 64'd0);

        // Round robin: ptr points at requester 1 after the single grant
        rsp_ready = 1'b1;
        set_req(2'b11, 40'h10, 40'h1, 40'h20, 40'h2);
        for (int c = 0; c < 4; c++) begin
            exp_g   = (c % 2 == 0) ? 2'b10 : 2'b01;
            exp_id  = (c % 2 == 0) ? 2'd1 : 2'd0;
            exp_res = (c % 2 == 0) ? 64'h22 : 64'h11;
            #3;
            check($sformatf("rr_ready%0d", c), 64'(req_ready), 64'(exp_g));
            step();
            check($sformatf("rr_valid%0d", c), 64'(rsp_valid), 64'd1);
            check($sformatf("rr_id%0d", c), 64'(rsp_id), 64'(exp_id));
            check($sformatf("rr_res%0d", c), 64'(rsp_res), exp_res);
        end

        // Backpressure: buffer holds requester 0's 0x11, both still requesting
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #3;
            check($sformatf("bp_ready%0d", c), 64'(req_ready), 64'd0);
            check($sformatf("bp_op1_%0d", c), 64'(adder_op1_o), 64'd0);
            step();
            check($sformatf("bp_res%0d", c), 64'(rsp_res), 64'h11);
            check($sformatf("bp_id%0d", c), 64'(rsp_id), 64'd0);
            check($sformatf("bp_valid%0d", c), 64'(rsp_valid), 64'd1);
        end
        rsp_ready = 1'b1;
        #3;
        check("bp_release_ready", 64'(req_ready), 64'h2);
        step();
        check("bp_release_id", 64'(rsp_id), 64'd1);
        check("bp_release_res", 64'(rsp_res), 64'h22);
        set_req(2'b00, 40'h0, 40'h0, 40'h0, 40'h0);
        step();
        check("drain_valid", 64'(rsp_valid), 64'd0);

        // Wrap-around at the top of the 40-bit range
        set_req(2'b01, 40'hFF_FFFF_FFFF, 40'h1, 40'h0, 40'h0);
        #3;
        check("wrap_ready", 64'(req_ready), 64'h1);
        step();
        check("wrap_valid", 64'(rsp_valid), 64'd1);
        check("wrap_res", 64'(rsp_res), 64'h0);

        // Fill the buffer, then stall and reset mid-cycle
        set_req(2'b10, 40'h0, 40'h0, 40'h5, 40'h6);
        #3;
        check("pre_rst_ready", 64'(req_ready), 64'h2);
        step();
        rsp_ready = 1'b0;
        set_req(2'b00, 40'h0, 40'h0, 40'h0, 40'h0);
        check("pre_rst_res", 64'(rsp_res), 64'hB);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(rsp_valid), 64'd0);
        check("async_rst_res", 64'(rsp_res), 64'd0);
        check("async_rst_id", 64'(rsp_id), 64'd0);
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        set_req(2'b11, 40'h1, 40'h2, 40'h3, 40'h4);
        #3;
        check("post_rst_ready", 64'(req_ready), 64'h1);
        step();
        check("post_rst_id", 64'(rsp_id), 64'd0);
        check("post_rst_res", 64'(rsp_res), 64'h3);

`ifdef E203_DSP_BIGADDER_ARB_LOCK_EN
        // ptr now at requester 1; it locks, then releases on its second beat
        req_lock = 2'b10;
        #3;
        check("lock_enter_ready", 64'(req_ready), 64'h2);
        step();
        req_lock = 2'b00;
        #3;
        check("lock_hold_ready", 64'(req_ready), 64'h2);
        step();
        check("lock_hold_id", 64'(rsp_id), 64'd1);
        #3;
        check("lock_release_ready", 64'(req_ready), 64'h1);
        step();
        check("lock_release_id", 64'(rsp_id), 64'd0);
`endif

        set_req(2'b00, 40'h0, 40'h0, 40'h0, 40'h0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
